// File: rtl/booth_mult_12bit_if.sv
// booth_mult_12bit_if: request/result bundle for the sequential Booth multiplier.
//   start         master->slave  request, sampled only while ready=1
//   multiplicand  master->slave  signed operand M, captured on accepted start
//   multiplier    master->slave  signed operand Q, captured on accepted start
//   ready         slave->master  multiplier idle, can accept start
//   busy          slave->master  Booth iterations in progress
//   result_valid  slave->master  one-cycle pulse, product/ovf freshly written
//   product       slave->master  signed M*Q, held until the next result
//   ovf           slave->master  product does not fit in WIDTH-bit signed
interface booth_mult_12bit_if #(
    parameter int unsigned WIDTH = 12
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 busy;
    logic                 result_valid;
    logic [2*WIDTH-1:0]   product;
    logic                 ovf;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, result_valid, product, ovf
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, result_valid, product, ovf
    );
endinterface

// File: rtl/booth_mult_12bit.sv
// booth_mult_12bit: sequential signed radix-2 Booth multiplier, one step per clock.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any operation in flight
//   bus      booth_mult_12bit_if.slave (start/operands in, ready/busy/result out)
// A start accepted in IDLE runs WIDTH Booth steps in RUN, then spends one cycle in
// DONE pulsing result_valid. product/ovf are only rewritten on entry to DONE.
module booth_mult_12bit #(
    parameter int unsigned WIDTH = 12
) (
    input logic               clock,
    input logic               reset_n,
    booth_mult_12bit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [WIDTH:0]     acc_q;      // A, one guard bit so that -M of the most negative M fits
    logic [WIDTH-1:0]   mq_q;       // Q, multiplier shifting out / product low half shifting in
    logic               q_m1_q;     // Q_-1
    logic [WIDTH-1:0]   mcand_q;    // M
    logic [3:0]         count_q;
    logic [2*WIDTH-1:0] product_q;
    logic               ovf_q;
    logic               valid_q;

    logic               do_sub;
    logic               do_add;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_lo;
    logic               carry_out;
    logic [WIDTH:0]     acc_upd;
    logic [WIDTH:0]     acc_nxt;
    logic [WIDTH-1:0]   mq_nxt;
    logic               q_m1_nxt;
    logic [2*WIDTH-1:0] product_nxt;
    logic               ovf_nxt;

    // One Booth step: optional add/sub of M, then arithmetic shift of {A,Q,Q_-1}.
    always_comb begin
        logic c;
        do_sub  = mq_q[0] & ~q_m1_q;
        do_add  = mq_q[0] ^ q_m1_q;
        // Subtraction is A + ~M + 1, the +1 entering as carry-in.
        addend  = do_sub ? ~mcand_q : mcand_q;
        sum_lo  = '0;
        c       = do_sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum_lo[i] = acc_q[i] ^ addend[i] ^ c;
            c         = (acc_q[i] & addend[i]) | (c & (acc_q[i] ^ addend[i]));
        end
        carry_out = c;
        // Guard bit: sign-extended operands plus the ripple carry-out.
        acc_upd  = do_add ? {acc_q[WIDTH] ^ addend[WIDTH-1] ^ carry_out, sum_lo} : acc_q;
        acc_nxt  = {acc_upd[WIDTH], acc_upd[WIDTH:1]};
        mq_nxt   = {acc_upd[0], mq_q[WIDTH-1:1]};
        q_m1_nxt = mq_q[0];
        // After the last step the exact product sits in {A[WIDTH-1:0], Q}.
        product_nxt = {acc_nxt[WIDTH-1:0], mq_nxt};
        // Fits in WIDTH-bit signed iff the top WIDTH+1 bits are all equal.
        ovf_nxt = ~(&product_nxt[2*WIDTH-1:WIDTH-1]) & (|product_nxt[2*WIDTH-1:WIDTH-1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mq_q      <= '0;
            q_m1_q    <= 1'b0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        mcand_q <= bus.multiplicand;
                        mq_q    <= bus.multiplier;
                        acc_q   <= '0;
                        q_m1_q  <= 1'b0;
                        count_q <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_nxt;
                    mq_q    <= mq_nxt;
                    q_m1_q  <= q_m1_nxt;
                    count_q <= count_q + 4'd1;
                    if (count_q == 4'(WIDTH - 1)) begin
                        state_q   <= StDone;
                        product_q <= product_nxt;
                        ovf_q     <= ovf_nxt;
                        valid_q   <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready        = (state_q == StIdle);
    assign bus.busy         = (state_q == StRun);
    assign bus.result_valid = valid_q;
    assign bus.product      = product_q;
    assign bus.ovf          = ovf_q;
endmodule
